// File: rtl/spi_mem_bridge_if.sv
// spi_mem_bridge_if
//   Serial-side bundle of the SPI memory bridge.
//   SS_n      slave select, active low       (master -> slave)
//   MOSI      serial command/data, MSB first (master -> slave)
//   MISO      serial read data, MSB first    (slave -> master)
//   busy      bridge is inside a frame       (slave -> master)
//   frame_err one-cycle aborted/mismatched frame pulse (slave -> master)
interface spi_mem_bridge_if;
  logic SS_n;
  logic MOSI;
  logic MISO;
  logic busy;
  logic frame_err;

  modport master (
    output SS_n,
    output MOSI,
    input  MISO,
    input  busy,
    input  frame_err
  );

  modport slave (
    input  SS_n,
    input  MOSI,
    output MISO,
    output busy,
    output frame_err
  );
endinterface

// File: rtl/spi_mem_bridge.sv
// spi_mem_bridge
//   Receives {cmd[1:0], payload[DATA_WIDTH-1:0]} frames MSB first on MOSI,
//   executes them on an internal single-port memory and shifts read data
//   back out on MISO.
//   cmd 00: load write address     cmd 01: write mem[wr_addr] = payload
//   cmd 10: load read address      cmd 11: read mem[rd_addr] onto MISO
// Ports
//   clk    single clock, everything happens on its rising edge
//   rst_n  synchronous active-low reset (memory contents are kept)
//   bus    slave side of spi_mem_bridge_if (SS_n, MOSI, MISO, busy, frame_err)
module spi_mem_bridge #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 2**ADDR_WIDTH,
  parameter int AUTO_INC   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  spi_mem_bridge_if.slave        bus
);
  localparam int F       = DATA_WIDTH + 2;
  localparam int MEM_AW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_MAX = F + 1 + DATA_WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Counter landmarks: word complete, first shift-out bit, frame finished.
  localparam logic [CNT_W-1:0]  CNT_WORD  = CNT_W'(F);
  localparam logic [CNT_W-1:0]  CNT_SH0   = CNT_W'(F + 1);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(CNT_MAX);
  localparam logic [31:0]       DEPTH_U   = 32'(MEM_DEPTH);
  localparam logic [MEM_AW-1:0] ADDR_LAST = MEM_AW'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_e;

  function automatic logic [MEM_AW-1:0] wrap_addr(input logic [ADDR_WIDTH-1:0] a);
    return MEM_AW'(32'(a) % DEPTH_U);
  endfunction

  function automatic logic [MEM_AW-1:0] next_addr(input logic [MEM_AW-1:0] a);
    return (a == ADDR_LAST) ? '0 : a + MEM_AW'(1);
  endfunction

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  // cmd[1] is consumed by the state decision, so only cmd[0]+payload are kept.
  logic [F-2:0]          word_q, word_d;
  logic [MEM_AW-1:0]     wr_addr_q, wr_addr_d;
  logic [MEM_AW-1:0]     rd_addr_q, rd_addr_d;
  logic                  rd_pending_q, rd_pending_d;
  logic [DATA_WIDTH-1:0] out_sh_q, out_sh_d;
  logic                  miso_q, miso_d;
  logic                  busy_q, busy_d;
  logic                  frame_err_q, frame_err_d;
  logic                  mem_we, mem_re;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_rd_q;

  logic                  cmd0;
  logic [ADDR_WIDTH-1:0] pay_addr;
  assign cmd0     = word_q[DATA_WIDTH];
  assign pay_addr = word_q[ADDR_WIDTH-1:0];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    rd_pending_d = rd_pending_q;
    out_sh_d     = out_sh_q;
    miso_d       = 1'b0;
    frame_err_d  = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!bus.SS_n) begin
          state_d = CHK_CMD;
          cnt_d   = '0;
          word_d  = '0;
        end
      end
      CHK_CMD: begin
        if (bus.SS_n) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else begin
          cnt_d = CNT_W'(1);
          if (!bus.MOSI)        state_d = WRITE;
          else if (rd_pending_q) state_d = READ_DATA;
          else                  state_d = READ_ADD;
        end
      end
      default: begin
        if (cnt_q < CNT_WORD) begin
          // Still receiving: losing SS_n here leaves an incomplete word.
          if (bus.SS_n) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
          end else begin
            word_d = {word_q[F-3:0], bus.MOSI};
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end else if (cnt_q == CNT_WORD) begin
          // Execute edge: the word is complete, so SS_n is not consulted.
          cnt_d = CNT_DONE;
          case (state_q)
            WRITE: begin
              if (!cmd0) begin
                wr_addr_d = wrap_addr(pay_addr);
              end else begin
                mem_we = 1'b1;
                if (AUTO_INC != 0) wr_addr_d = next_addr(wr_addr_q);
              end
            end
            READ_ADD: begin
              if (cmd0) begin
                frame_err_d = 1'b1;
              end else begin
                rd_addr_d    = wrap_addr(pay_addr);
                rd_pending_d = 1'b1;
              end
            end
            default: begin // READ_DATA
              if (!cmd0) begin
                frame_err_d = 1'b1;
              end else begin
                mem_re       = 1'b1;
                rd_pending_d = 1'b0;
                cnt_d        = CNT_SH0;
                if (AUTO_INC != 0) rd_addr_d = next_addr(rd_addr_q);
              end
            end
          endcase
        end else if (bus.SS_n) begin
          // Complete frame: leaving during shift-out or hold is not an error.
          state_d = IDLE;
        end else if (cnt_q < CNT_DONE) begin
          // Shift-out. The first bit comes straight from the memory read
          // register, later bits from the local shifter.
          if (cnt_q == CNT_SH0) begin
            miso_d   = mem_rd_q[DATA_WIDTH-1];
            out_sh_d = mem_rd_q << 1;
          end else begin
            miso_d   = out_sh_q[DATA_WIDTH-1];
            out_sh_d = out_sh_q << 1;
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase

    busy_d = (state_d != IDLE);

    // Reset must also win over a memory write scheduled for this edge.
    if (!rst_n) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      word_q       <= '0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      rd_pending_q <= 1'b0;
      out_sh_q     <= '0;
      miso_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      rd_pending_q <= rd_pending_d;
      out_sh_q     <= out_sh_d;
      miso_q       <= miso_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Single-port memory with registered read; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr_q] <= word_q[DATA_WIDTH-1:0];
    if (mem_re) mem_rd_q <= mem[rd_addr_q];
  end

  assign bus.MISO      = miso_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_mem_bridge.sv
module tb_spi_mem_bridge;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] ss, mosi;
  logic [2:0] miso_o, busy_o, ferr_o;

  spi_mem_bridge_if bus0();
  spi_mem_bridge_if bus1();
  spi_mem_bridge_if bus2();

  assign bus0.SS_n = ss[0];  assign bus0.MOSI = mosi[0];
  assign bus1.SS_n = ss[1];  assign bus1.MOSI = mosi[1];
  assign bus2.SS_n = ss[2];  assign bus2.MOSI = mosi[2];
  assign miso_o = {bus2.MISO, bus1.MISO, bus0.MISO};
  assign busy_o = {bus2.busy, bus1.busy, bus0.busy};
  assign ferr_o = {bus2.frame_err, bus1.frame_err, bus0.frame_err};

  spi_mem_bridge #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .AUTO_INC(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  spi_mem_bridge #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .AUTO_INC(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  spi_mem_bridge #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .AUTO_INC(0))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  // Reference model: per-instance memory image and address registers.
  int          dws [3] = '{8, 8, 16};
  int          aws [3] = '{8, 8, 4};
  int          ais [3] = '{0, 1, 0};
  logic [15:0] mm  [3][256];
  bit          kn  [3][256];
  int          wa  [3];
  int          ra  [3];
  bit          rp  [3];

  int total = 0;
  int bad   = 0;
  int err_seen   [3] = '{0, 0, 0};
  int miso_extra [3] = '{0, 0, 0};
  bit in_shift = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: rising edge, then observe on the falling edge.
  task automatic step(input int sel);
    @(posedge clk);
    @(negedge clk);
    err_seen[sel] += int'(ferr_o[sel]);
    if (!in_shift && miso_o[sel] !== 1'b0) miso_extra[sel]++;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      wa[s] = 0;
      ra[s] = 0;
      rp[s] = 1'b0;
    end
  endtask

  // Sends nbits of the frame (a full frame when nbits == F), checks the
  // outcome against the model. rst_k >= 0 asserts reset after read bit rst_k.
  task automatic run_frame(input int sel, input logic [1:0] cmd, input logic [15:0] pay,
                           input int nbits, input int rst_k);
    int          dw, f, e0, m0;
    logic [31:0] fr;
    logic [15:0] dmask, amask, rdv;
    bit          mis, rd, rdk;
    string       nm;
    dw    = dws[sel];
    f     = dw + 2;
    dmask = 16'((32'd1 << dw) - 32'd1);
    amask = 16'((32'd1 << aws[sel]) - 32'd1);
    fr    = (32'(cmd) << dw) | 32'(pay & dmask);
    e0    = err_seen[sel];
    m0    = miso_extra[sel];
    nm    = $sformatf("u%0d cmd%b", sel, cmd);
    mis = 1'b0; rd = 1'b0; rdk = 1'b0; rdv = '0;

    ss[sel]   = 1'b0;
    mosi[sel] = fr[f-1];
    step(sel);                         // edge 0
    for (int i = 0; i < nbits; i++) begin
      mosi[sel] = fr[f-1-i];
      step(sel);                       // edge i+1
    end

    if (nbits < f) begin
      ss[sel] = 1'b1;
      step(sel);
      check_val({nm, " abort busy"}, 32'(busy_o[sel]), 32'd0);
      check_val({nm, " abort err"}, 32'(ferr_o[sel]), 32'd1);
      step(sel);
      check_val({nm, " abort err pulses"}, 32'(err_seen[sel] - e0), 32'd1);
      check_val({nm, " abort miso"}, 32'(miso_extra[sel] - m0), 32'd0);
      $display("u%0d cmd=%b pay=%h bits=%0d aborted", sel, cmd, pay, nbits);
      return;
    end

    if (!cmd[1]) begin
      if (!cmd[0]) wa[sel] = int'(pay & amask);
      else begin
        mm[sel][wa[sel]] = pay & dmask;
        kn[sel][wa[sel]] = 1'b1;
        if (ais[sel] != 0) wa[sel] = int'(16'(wa[sel] + 1) & amask);
      end
    end else if (!rp[sel]) begin
      if (cmd[0]) mis = 1'b1;
      else begin
        ra[sel] = int'(pay & amask);
        rp[sel] = 1'b1;
      end
    end else begin
      if (!cmd[0]) mis = 1'b1;
      else begin
        rd  = 1'b1;
        rdv = mm[sel][ra[sel]];
        rdk = kn[sel][ra[sel]];
        rp[sel] = 1'b0;
        if (ais[sel] != 0) ra[sel] = int'(16'(ra[sel] + 1) & amask);
      end
    end

    step(sel);                         // edge F+1
    check_val({nm, " exec err"}, 32'(ferr_o[sel]), 32'(mis));
    check_val({nm, " exec busy"}, 32'(busy_o[sel]), 32'd1);

    if (rd) begin
      in_shift = 1'b1;
      for (int k = 0; k < dw; k++) begin
        step(sel);                     // edge F+2+k
        if (rdk) check_val($sformatf("%s miso%0d", nm, k), 32'(miso_o[sel]), 32'(rdv[dw-1-k]));
        if (k == rst_k) begin
          in_shift = 1'b0;
          rst_n    = 1'b0;
          step(sel);
          check_val({nm, " rst miso"}, 32'(miso_o[sel]), 32'd0);
          check_val({nm, " rst busy"}, 32'(busy_o), 32'd0);
          check_val({nm, " rst err"}, 32'(ferr_o), 32'd0);
          rst_n   = 1'b1;
          ss[sel] = 1'b1;
          model_reset();
          $display("u%0d cmd=%b pay=%h reset during read bit %0d", sel, cmd, pay, k);
          return;
        end
      end
      in_shift = 1'b0;
      step(sel);
      check_val({nm, " miso after"}, 32'(miso_o[sel]), 32'd0);
    end

    ss[sel] = 1'b1;
    step(sel);
    check_val({nm, " idle busy"}, 32'(busy_o[sel]), 32'd0);
    check_val({nm, " err pulses"}, 32'(err_seen[sel] - e0), 32'(mis));
    check_val({nm, " stray miso"}, 32'(miso_extra[sel] - m0), 32'd0);
    $display("u%0d cmd=%b pay=%h bits=%0d mismatch=%0d%s", sel, cmd, pay, nbits, mis,
             rd ? $sformatf(" read=%h", rdv) : "");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    ss    = 3'b111;
    mosi  = 3'b000;
    model_reset();
    for (int s = 0; s < 3; s++)
      for (int a = 0; a < 256; a++) kn[s][a] = 1'b0;
    repeat (3) step(0);
    check_val("reset miso", 32'(miso_o), 32'd0);
    check_val("reset busy", 32'(busy_o), 32'd0);
    check_val("reset err", 32'(ferr_o), 32'd0);
    rst_n = 1'b1;
    step(0);

    // Write then read back on the 8-bit instance.
    run_frame(0, 2'b00, 16'h3C, 10, -1);
    run_frame(0, 2'b01, 16'hA5, 10, -1);
    run_frame(0, 2'b10, 16'h3C, 10, -1);
    run_frame(0, 2'b11, 16'h00, 10, -1);
    run_frame(0, 2'b11, 16'h00, 10, -1);   // read pending now clear: mismatch

    // Auto-increment burst with address wrap.
    run_frame(1, 2'b00, 16'hFF, 10, -1);
    run_frame(1, 2'b01, 16'h11, 10, -1);
    run_frame(1, 2'b01, 16'h22, 10, -1);
    run_frame(1, 2'b10, 16'hFF, 10, -1);
    run_frame(1, 2'b11, 16'h00, 10, -1);
    run_frame(1, 2'b10, 16'h00, 10, -1);
    run_frame(1, 2'b11, 16'h00, 10, -1);

    // Abort after 5 bits leaves memory untouched; next frame executes.
    run_frame(0, 2'b01, 16'h77, 5, -1);
    run_frame(0, 2'b10, 16'h3C, 10, -1);
    run_frame(0, 2'b11, 16'h00, 10, -1);
    run_frame(0, 2'b01, 16'h77, 10, -1);
    run_frame(0, 2'b11, 16'h00, 10, -1);   // mismatch, MISO stays low
    run_frame(0, 2'b10, 16'h3C, 10, -1);

    // Reset during shift-out bit 3, then addresses/pending must be cleared.
    run_frame(0, 2'b11, 16'h00, 10, 3);
    run_frame(0, 2'b11, 16'h00, 10, -1);
    run_frame(0, 2'b01, 16'h5A, 10, -1);
    run_frame(0, 2'b10, 16'h3C, 10, -1);
    run_frame(0, 2'b11, 16'h00, 10, -1);
    run_frame(0, 2'b10, 16'h00, 10, -1);
    run_frame(0, 2'b11, 16'h00, 10, -1);

    // 16-bit data, 4-bit address with wrap.
    run_frame(2, 2'b00, 16'h0005, 18, -1);
    run_frame(2, 2'b01, 16'hBEEF, 18, -1);
    run_frame(2, 2'b10, 16'h0015, 18, -1);
    run_frame(2, 2'b11, 16'h0000, 18, -1);

    // Randomized traffic on all three instances.
    for (int s = 0; s < 3; s++) begin
      for (int n = 0; n < 40; n++) begin
        logic [1:0]  c;
        logic [15:0] p;
        int          nb;
        c = 2'($urandom_range(0, 3));
        if (rp[s] && $urandom_range(0, 3) != 0) c = 2'b11;
        p = 16'($urandom);
        if (s < 2 && !c[0]) p = 16'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) nb = int'($urandom_range(0, 32'(dws[s] + 1)));
        else nb = dws[s] + 2;
        run_frame(s, c, p, nb, -1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
